// File: rtl/uart_rst_seq.sv
// ---------------------------------------------------------------------------
// uart_rst_seq
// Reset sequencer for the UART core. After the synchronized reset falls it
// keeps every submodule in reset for HOLD_CYC cycles, then releases the baud
// generator. It waits for the first baud tick, then releases the receiver.
// After GAP_CYC further cycles it releases the transmitter and reports ready.
// A host soft reset is accepted only while running. Resets are re-asserted
// only once the transmitter has finished its current frame.
//
// Optional feature macro: RSTSEQ_WDOG_EN
//   When this macro is defined, a watchdog limits the wait for the first baud
//   tick to WDOG_CYC cycles. On expiry the sequencer sets the sticky
//   wdog_err_o flag and retries from HOLD. Without the macro, wdog_err_o is
//   tied to 0.
//
// Ports:
//   clk         in   system clock, all logic on posedge
//   reset       in   synchronous active-high reset
//   baud_tick   in   one-cycle strobe from the baud generator
//   tx_busy     in   transmitter is mid-frame
//   soft_req    in   host soft-reset request (level)
//   soft_ack    out  one-cycle pulse: soft reset accepted, resets re-asserted
//   rst_baud_o  out  baud generator reset, active-high
//   rst_rx_o    out  receiver reset, active-high
//   rst_tx_o    out  transmitter reset, active-high
//   ready_o     out  all submodules released and running
//   wdog_err_o  out  sticky baud-tick watchdog expiry flag
// ---------------------------------------------------------------------------
module uart_rst_seq #(
  parameter int HOLD_CYC = 16,
  parameter int GAP_CYC  = 4,
  parameter int WDOG_CYC = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic baud_tick,
  input  logic tx_busy,
  input  logic soft_req,
  output logic soft_ack,
  output logic rst_baud_o,
  output logic rst_rx_o,
  output logic rst_tx_o,
  output logic ready_o,
  output logic wdog_err_o
);

  localparam int MAX_HG  = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int MAX_CYC = (MAX_HG > WDOG_CYC) ? MAX_HG : WDOG_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

  localparam logic [2:0] S_HOLD    = 3'd0;
  localparam logic [2:0] S_BAUD_UP = 3'd1;
  localparam logic [2:0] S_RX_UP   = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;
  localparam logic [2:0] S_ACK     = 3'd5;

  logic [2:0]       r_state;
  logic [2:0]       w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_cnt_en;

`ifdef RSTSEQ_WDOG_EN
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYC - 1);
  logic r_wdog_err;
  logic w_wdog_trip;
`endif

  // Next-state and counter-enable decode
  always_comb begin
    w_next_state = r_state;
    w_cnt_en     = 1'b0;
`ifdef RSTSEQ_WDOG_EN
    w_wdog_trip  = 1'b0;
`endif
    case (r_state)
      S_HOLD: begin
        w_cnt_en = 1'b1;
        if (r_cnt == HOLD_LAST) w_next_state = S_BAUD_UP;
      end
      S_BAUD_UP: begin
`ifdef RSTSEQ_WDOG_EN
        w_cnt_en = 1'b1;
        // A tick on the expiry edge still counts as success.
        if (baud_tick) begin
          w_next_state = S_RX_UP;
        end else if (r_cnt == WDOG_LAST) begin
          w_next_state = S_HOLD;
          w_wdog_trip  = 1'b1;
        end
`else
        if (baud_tick) w_next_state = S_RX_UP;
`endif
      end
      S_RX_UP: begin
        w_cnt_en = 1'b1;
        if (r_cnt == GAP_LAST) w_next_state = S_RUN;
      end
      S_RUN: begin
        if (soft_req) w_next_state = S_DRAIN;
      end
      S_DRAIN: begin
        if (!tx_busy) w_next_state = S_ACK;
      end
      S_ACK: begin
        w_next_state = S_HOLD;
      end
      default: begin
        w_next_state = S_HOLD;
      end
    endcase
  end

  // State and shared counter; counter restarts from zero on every transition
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_HOLD;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_next_state != r_state) begin
        r_cnt <= '0;
      end else if (w_cnt_en) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

`ifdef RSTSEQ_WDOG_EN
  // Sticky error flag: only the external reset clears it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wdog_err <= 1'b0;
    end else if (w_wdog_trip) begin
      r_wdog_err <= 1'b1;
    end
  end

  assign wdog_err_o = r_wdog_err;
`else
  assign wdog_err_o = 1'b0;
`endif

  // Moore output decode from the registered state
  always_comb begin
    rst_baud_o = 1'b1;
    rst_rx_o   = 1'b1;
    rst_tx_o   = 1'b1;
    ready_o    = 1'b0;
    soft_ack   = 1'b0;
    case (r_state)
      S_HOLD: begin
        rst_baud_o = 1'b1;
        rst_rx_o   = 1'b1;
        rst_tx_o   = 1'b1;
      end
      S_BAUD_UP: begin
        rst_baud_o = 1'b0;
      end
      S_RX_UP: begin
        rst_baud_o = 1'b0;
        rst_rx_o   = 1'b0;
      end
      S_RUN: begin
        rst_baud_o = 1'b0;
        rst_rx_o   = 1'b0;
        rst_tx_o   = 1'b0;
        ready_o    = 1'b1;
      end
      S_DRAIN: begin
        rst_baud_o = 1'b0;
        rst_rx_o   = 1'b0;
        rst_tx_o   = 1'b0;
      end
      S_ACK: begin
        soft_ack = 1'b1;
      end
      default: begin
        rst_baud_o = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rst_seq.sv
// ---------------------------------------------------------------------------
// tb_uart_rst_seq
// Self-checking bench for uart_rst_seq with default HOLD_CYC/GAP_CYC.
// Expected output vectors {baud, rx, tx, ready, ack, wdog} are derived from
// the documented release schedule. They are queued when the stimulus for an
// edge is driven, then popped and compared #1 after that edge.
// Watchdog scenarios run only when RSTSEQ_WDOG_EN is defined (WDOG_CYC=8).
// ---------------------------------------------------------------------------
module tb_uart_rst_seq;

  localparam int HOLD_C = 16;
  localparam int GAP_C  = 4;
`ifdef RSTSEQ_WDOG_EN
  localparam int WDOG_C = 8;
`else
  localparam int WDOG_C = 1023;
`endif

  logic clk;
  logic reset;
  logic baud_tick;
  logic tx_busy;
  logic soft_req;
  logic soft_ack;
  logic rst_baud_o;
  logic rst_rx_o;
  logic rst_tx_o;
  logic ready_o;
  logic wdog_err_o;

  int tests  = 0;
  int failed = 0;

  logic [5:0] exp_q[$];
  logic [5:0] got;
  logic [5:0] expv;

  uart_rst_seq #(
    .HOLD_CYC (HOLD_C),
    .GAP_CYC  (GAP_C),
    .WDOG_CYC (WDOG_C)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .baud_tick  (baud_tick),
    .tx_busy    (tx_busy),
    .soft_req   (soft_req),
    .soft_ack   (soft_ack),
    .rst_baud_o (rst_baud_o),
    .rst_rx_o   (rst_rx_o),
    .rst_tx_o   (rst_tx_o),
    .ready_o    (ready_o),
    .wdog_err_o (wdog_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs after edge n, counted from HOLD entry, with the first
  // baud tick at edge t and a watchdog flag value w.
  function automatic logic [5:0] sched(input int n, input int t, input logic w);
    logic b, r, x, rdy;
    b   = (n < HOLD_C);
    r   = (n < t);
    x   = (n < t + GAP_C);
    rdy = (n >= t + GAP_C);
    return {b, r, x, rdy, 1'b0, w};
  endfunction

  // Reset and run the normal power-up (tick at edge 20) up to RUN, unchecked
  task automatic bring_up();
    reset = 1'b1; baud_tick = 1'b0; tx_busy = 1'b0; soft_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int n = 1; n <= 26; n++) begin
      baud_tick = (n == 20);
      @(posedge clk); #1;
    end
    baud_tick = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; baud_tick = 1'b1; tx_busy = 1'b0; soft_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(6'b111000);
      @(posedge clk); #1;
      got  = {rst_baud_o, rst_rx_o, rst_tx_o, ready_o, soft_ack, wdog_err_o};
      expv = exp_q.pop_front();
      tests++;
      if (got !== expv) begin
        failed++;
        $display("FAIL reset cyc %0d got %b expected %b", i, got, expv);
      end
    end
    baud_tick = 1'b0; soft_req = 1'b0;
  endtask

  task automatic test_powerup();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int n = 1; n <= 26; n++) begin
      baud_tick = (n == 20);
      exp_q.push_back(sched(n, 20, 1'b0));
      @(posedge clk); #1;
      got  = {rst_baud_o, rst_rx_o, rst_tx_o, ready_o, soft_ack, wdog_err_o};
      expv = exp_q.pop_front();
      tests++;
      if (got !== expv) begin
        failed++;
        $display("FAIL powerup edge %0d got %b expected %b", n, got, expv);
      end
    end
    baud_tick = 1'b0;
  endtask

  task automatic test_soft_reset();
    bring_up();
    for (int n = 1; n <= 38; n++) begin
      soft_req  = (n <= 11);
      tx_busy   = (n <= 10);
      baud_tick = (n == 32);
      if (n <= 10)      exp_q.push_back(6'b000000);
      else if (n == 11) exp_q.push_back(6'b111010);
      else              exp_q.push_back(sched(n - 12, 20, 1'b0));
      @(posedge clk); #1;
      got  = {rst_baud_o, rst_rx_o, rst_tx_o, ready_o, soft_ack, wdog_err_o};
      expv = exp_q.pop_front();
      tests++;
      if (got !== expv) begin
        failed++;
        $display("FAIL soft_reset edge %0d got %b expected %b", n, got, expv);
      end
    end
    soft_req = 1'b0; tx_busy = 1'b0; baud_tick = 1'b0;
  endtask

  task automatic test_ignore_soft();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int n = 1; n <= 27; n++) begin
      soft_req  = (n == 5) || (n == 18) || (n == 22);
      baud_tick = (n == 8) || (n == 20);
      exp_q.push_back(sched(n, 20, 1'b0));
      @(posedge clk); #1;
      got  = {rst_baud_o, rst_rx_o, rst_tx_o, ready_o, soft_ack, wdog_err_o};
      expv = exp_q.pop_front();
      tests++;
      if (got !== expv) begin
        failed++;
        $display("FAIL ignore_soft edge %0d got %b expected %b", n, got, expv);
      end
    end
    soft_req = 1'b0; baud_tick = 1'b0;
  endtask

  task automatic test_reset_midseq();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    // Reset pulse while in RX_UP
    for (int n = 1; n <= 22; n++) begin
      reset     = (n == 22);
      baud_tick = (n == 20);
      exp_q.push_back((n == 22) ? 6'b111000 : sched(n, 20, 1'b0));
      @(posedge clk); #1;
      got  = {rst_baud_o, rst_rx_o, rst_tx_o, ready_o, soft_ack, wdog_err_o};
      expv = exp_q.pop_front();
      tests++;
      if (got !== expv) begin
        failed++;
        $display("FAIL rst_rxup edge %0d got %b expected %b", n, got, expv);
      end
    end
    // Restart from edge 1, then a reset pulse while in DRAIN
    for (int n = 1; n <= 28; n++) begin
      reset     = (n == 28);
      baud_tick = (n == 20);
      soft_req  = (n >= 27);
      tx_busy   = (n >= 27);
      if (n == 28)      exp_q.push_back(6'b111000);
      else if (n == 27) exp_q.push_back(6'b000000);
      else              exp_q.push_back(sched(n, 20, 1'b0));
      @(posedge clk); #1;
      got  = {rst_baud_o, rst_rx_o, rst_tx_o, ready_o, soft_ack, wdog_err_o};
      expv = exp_q.pop_front();
      tests++;
      if (got !== expv) begin
        failed++;
        $display("FAIL rst_drain edge %0d got %b expected %b", n, got, expv);
      end
    end
    reset = 1'b0; soft_req = 1'b0; tx_busy = 1'b0; baud_tick = 1'b0;
    // Sequence restarts from edge 1 (no tick supplied)
    for (int n = 1; n <= 17; n++) begin
      exp_q.push_back(sched(n, 1000, 1'b0));
      @(posedge clk); #1;
      got  = {rst_baud_o, rst_rx_o, rst_tx_o, ready_o, soft_ack, wdog_err_o};
      expv = exp_q.pop_front();
      tests++;
      if (got !== expv) begin
        failed++;
        $display("FAIL rst_restart edge %0d got %b expected %b", n, got, expv);
      end
    end
  endtask

`ifdef RSTSEQ_WDOG_EN
  task automatic test_wdog_expire();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int n = 1; n <= 48; n++) begin
      baud_tick = (n == 43);
      if (n < 16)      exp_q.push_back(6'b111000);
      else if (n < 24) exp_q.push_back(6'b011000);
      else             exp_q.push_back(sched(n - 24, 43 - 24, 1'b1));
      @(posedge clk); #1;
      got  = {rst_baud_o, rst_rx_o, rst_tx_o, ready_o, soft_ack, wdog_err_o};
      expv = exp_q.pop_front();
      tests++;
      if (got !== expv) begin
        failed++;
        $display("FAIL wdog_expire edge %0d got %b expected %b", n, got, expv);
      end
    end
    baud_tick = 1'b0;
  endtask

  task automatic test_wdog_edge_tick();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      baud_tick = (n == 24);
      exp_q.push_back(sched(n, 24, 1'b0));
      @(posedge clk); #1;
      got  = {rst_baud_o, rst_rx_o, rst_tx_o, ready_o, soft_ack, wdog_err_o};
      expv = exp_q.pop_front();
      tests++;
      if (got !== expv) begin
        failed++;
        $display("FAIL wdog_edge_tick edge %0d got %b expected %b", n, got, expv);
      end
    end
    baud_tick = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1; baud_tick = 1'b0; tx_busy = 1'b0; soft_req = 1'b0;
    test_reset();
    test_powerup();
    test_soft_reset();
    test_ignore_soft();
    test_reset_midseq();
`ifdef RSTSEQ_WDOG_EN
    test_wdog_expire();
    test_wdog_edge_tick();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/uart_rst_seq.md
# uart_rst_seq

Reset sequencer for the UART core. It takes the synchronized active-high reset and releases the per-submodule resets in a fixed order: baud generator, then receiver, then transmitter. Each release is gated by a hold timer, a baud-tick handshake and a gap timer. It also services host soft-reset requests and waits for any transmitter frame to drain before re-asserting resets. It sits between the reset synchronizer and the baud, RX and TX blocks.

## Interface
Parameters:
- HOLD_CYC, 16: cycles all resets stay asserted after `reset` falls (>=1)
- GAP_CYC, 4: cycles between RX release and TX release (>=1)
- WDOG_CYC, 1023: maximum cycles to wait for the first baud tick (watchdog builds only, >=1)

Ports:
- clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high; one clock, no other clock or reset
- baud_tick  in  1  one-cycle strobe from the baud generator
- tx_busy  in  1  transmitter mid-frame
- soft_req  in  1  host soft-reset request (level)
- soft_ack  out  1  one-cycle pulse: soft reset accepted, resets re-asserted
- rst_baud_o  out  1  baud generator reset, active-high
- rst_rx_o  out  1  receiver reset, active-high
- rst_tx_o  out  1  transmitter reset, active-high
- ready_o  out  1  all submodules released and running
- wdog_err_o  out  1  sticky: baud tick watchdog expired

## Operation
- One state register and one shared counter. The counter clears on every state change. Counter width is clog2(max(HOLD_CYC, GAP_CYC, WDOG_CYC)+1).
- All outputs are decoded from registered state (Moore) and change only on clock edges.
- Outputs per state, listed as baud/rx/tx/ready:
  - HOLD = 1/1/1/0
  - BAUD_UP = 0/1/1/0
  - RX_UP = 0/0/1/0
  - RUN = 0/0/0/1
  - DRAIN = 0/0/0/0
  - ACK = 1/1/1/0, with soft_ack=1 in ACK only
- HOLD: counter increments each cycle. When counter==HOLD_CYC-1, go to BAUD_UP.
- BAUD_UP: when baud_tick=1, go to RX_UP. Without the watchdog this waits indefinitely.
- RX_UP: counter increments each cycle. When counter==GAP_CYC-1, go to RUN.
- RUN: when soft_req=1, go to DRAIN.
- DRAIN: when tx_busy=0, go to ACK. If tx_busy=0 on the entry cycle, ACK follows one cycle after entry.
- ACK: lasts exactly one cycle, then HOLD, and the full sequence reruns.
- soft_req is sampled only in RUN. It is ignored and not queued in all other states. If soft_req is still high when RUN is re-entered, another soft reset starts. The host drops soft_req after seeing soft_ack.
- baud_tick is ignored outside BAUD_UP.
- reset=1 at any edge, in any state, forces HOLD with counter=0. Reset values:
  - rst_baud_o=1, rst_rx_o=1, rst_tx_o=1
  - ready_o=0, soft_ack=0, wdog_err_o=0

## Timing
- Edge n means the n-th rising edge at which reset is sampled low.
- rst_baud_o falls after edge HOLD_CYC (edge 16 with defaults).
- baud_tick sampled high at edge T, while in BAUD_UP: rst_rx_o falls after T.
- rst_tx_o falls and ready_o rises after edge T+GAP_CYC.
- soft_req high at edge S, while in RUN, with tx_busy low at S+1: DRAIN after S, soft_ack high for the cycle after S+1, HOLD after S+2.
- Worst-case time from soft_req to resets asserted is the remaining TX frame time plus 2 cycles.

## Configuration
- RSTSEQ_WDOG_EN defined:
  - In BAUD_UP the counter increments each cycle.
  - If counter==WDOG_CYC-1 and baud_tick=0, set wdog_err_o (sticky until `reset`) and return to HOLD to retry.
  - baud_tick=1 on that same edge wins: go to RX_UP, no error.
  - A later successful sequence does not clear wdog_err_o.
- RSTSEQ_WDOG_EN undefined: no watchdog compare, wdog_err_o tied 0, and WDOG_CYC is unused.

## Test plan
- Power-up, defaults, baud_tick at edge 20: rst_baud_o falls after edge 16, rst_rx_o after edge 20, rst_tx_o and ready_o after edge 24.
- Soft reset, defaults:
  - Setup: in RUN, soft_req=1 and tx_busy=1 for 10 cycles, then tx_busy=0.
  - Required: no reset asserts while tx_busy=1; soft_ack is one cycle; all resets =1 in ACK; ready_o returns after the full sequence.
- soft_req pulsed during HOLD, BAUD_UP and RX_UP: ignored; ready_o rises on normal schedule; no soft_ack.
- reset=1 for one cycle while in RX_UP, then again while in DRAIN: next edge shows all resets=1, ready_o=0, soft_ack=0; sequence restarts from edge 1.
- RSTSEQ_WDOG_EN, WDOG_CYC=8, no baud_tick: wdog_err_o=1 after 8 cycles in BAUD_UP; rst_baud_o=1 again; retries repeat; tick later gives ready_o=1 with wdog_err_o still 1.
- RSTSEQ_WDOG_EN, WDOG_CYC=8, baud_tick on the 8th BAUD_UP cycle: RX_UP entered, wdog_err_o=0.
